// File: rtl/up_core_p_pkg.sv
// up_core_p_pkg: opcodes, FSM states and instruction field positions shared by the core and its interrupt controller
package up_core_p_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPND, S_EXEC, S_WB, S_INT, S_HALT} state_e;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_PUSH = 4'hC;
  localparam logic [3:0] OP_POP  = 4'hD;
  localparam logic [3:0] OP_IE   = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;
  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 2;
  localparam int RS_HI = 1;
  localparam int RS_LO = 0;
  localparam int SUB_BIT = 0;
  function automatic logic has_opnd(input logic [3:0] op);
    return op == OP_LDI || op == OP_BEQ || op == OP_JMP || op == OP_CALL;
  endfunction
endpackage

// File: rtl/up_core_p_irq_ctrl.sv
// up_irq_ctrl: rising-edge irq capture into pending, lowest-index priority select, one-hot ack when take_i (in: clk, rst, irq_i, take_i; out: pending_o, idx_o, ack_o)
module up_irq_ctrl #(
  parameter int NUM_INT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] irq_i,
  input  logic               take_i,
  output logic [NUM_INT-1:0] pending_o,
  output logic [2:0]         idx_o,
  output logic [NUM_INT-1:0] ack_o
);
  logic [NUM_INT-1:0] irq_q, pend_q, sel;
  always_comb begin
    sel = '0;
    idx_o = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel = '0;
        sel[i] = 1'b1;
        idx_o = 3'(i);
      end
    end
  end
  assign ack_o = take_i ? sel : '0;
  assign pending_o = pend_q;
  // a fresh edge wins over a same-cycle clear so no request is lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_q <= '0;
      pend_q <= '0;
    end else begin
      irq_q <= irq_i;
      pend_q <= (pend_q & ~ack_o) | (irq_i & ~irq_q);
    end
endmodule

// File: rtl/up_core_p.sv
// up_core_p: byte-coded 4-register micro core with sync memory port and vectored interrupts (in: clk, rst, irq, mem_rdata; out: mem_addr, mem_wdata, mem_we, irq_ack, halted)
module up_core_p
  import up_core_p_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_INT  = 4,
  parameter int RESET_PC = 8,
  parameter int VEC_BASE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] irq,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [NUM_INT-1:0] irq_ack,
  output logic               halted
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_e state_q;
  logic [ADDR_W-1:0] pc_q, sp_q;
  logic [DATA_W-1:0] r_q [4];
  logic [7:0] ir_q;
  logic ie_q;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [DATA_W-1:0] a, b, alu;
  logic [NUM_INT-1:0] pending;
  logic [2:0] idx;
  assign op = ir_q[OP_HI:OP_LO];
  assign rd = ir_q[RD_HI:RD_LO];
  assign rs = ir_q[RS_HI:RS_LO];
  assign a = r_q[rd];
  assign b = r_q[rs];
  assign alu = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_NAND ? ~(a & b) : op == OP_XOR ? a ^ b : b;
  assign halted = state_q == S_HALT;
  up_irq_ctrl #(.NUM_INT(NUM_INT)) u_irq (
    .clk(clk),
    .rst(rst),
    .irq_i(irq),
    .take_i(state_q == S_INT),
    .pending_o(pending),
    .idx_o(idx),
    .ack_o(irq_ack)
  );
  // pops address sp+1 up front so the data arrives in WB
  always_comb begin
    mem_addr = pc_q;
    mem_we = 1'b0;
    mem_wdata = '0;
    if (state_q == S_EXEC) begin
      mem_addr = (op == OP_LD || op == OP_ST) ? b[ADDR_W-1:0] : (op == OP_PUSH || op == OP_CALL) ? sp_q : (op == OP_POP || op == OP_RET) ? sp_q + ONE : pc_q;
      mem_we = op == OP_ST || op == OP_PUSH || op == OP_CALL;
      mem_wdata = op == OP_CALL ? DATA_W'(pc_q) : a;
    end else if (state_q == S_INT) begin
      mem_addr = sp_q;
      mem_we = 1'b1;
      mem_wdata = DATA_W'(pc_q);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= ADDR_W'(RESET_PC);
      sp_q <= '1;
      r_q <= '{default: '0};
      ir_q <= '0;
      ie_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= (ie_q && |pending) ? S_INT : S_DECODE;
        S_DECODE: begin
          ir_q <= mem_rdata[7:0];
          pc_q <= pc_q + ONE;
          state_q <= has_opnd(mem_rdata[OP_HI:OP_LO]) ? S_OPND : S_EXEC;
        end
        S_OPND: begin
          pc_q <= pc_q + ONE;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_MOV: r_q[rd] <= alu;
            OP_LDI: r_q[rd] <= mem_rdata;
            OP_LD: state_q <= S_WB;
            OP_BEQ: if (a == b) pc_q <= mem_rdata[ADDR_W-1:0];
            OP_JMP: pc_q <= mem_rdata[ADDR_W-1:0];
            OP_CALL: begin
              pc_q <= mem_rdata[ADDR_W-1:0];
              sp_q <= sp_q - ONE;
            end
            OP_RET: begin
              sp_q <= sp_q + ONE;
              ie_q <= ie_q | ir_q[SUB_BIT];
              state_q <= S_WB;
            end
            OP_PUSH: sp_q <= sp_q - ONE;
            OP_POP: begin
              sp_q <= sp_q + ONE;
              state_q <= S_WB;
            end
            OP_IE: ie_q <= ir_q[SUB_BIT];
            OP_SYS: if (ir_q[SUB_BIT]) state_q <= S_HALT;
            default: ;
          endcase
        end
        S_WB: begin
          if (op == OP_RET) pc_q <= mem_rdata[ADDR_W-1:0];
          else r_q[rd] <= mem_rdata;
          state_q <= S_FETCH;
        end
        S_INT: begin
          pc_q <= ADDR_W'(VEC_BASE) + ADDR_W'(idx);
          sp_q <= sp_q - ONE;
          ie_q <= 1'b0;
          state_q <= S_FETCH;
        end
        S_HALT: if (|pending) state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
endmodule

// File: doc/up_core_p.md
# up_core_p

Parametrised successor to the nibble-coded micro core: an 8-opcode-nibble, byte-coded accumulator-free register machine with configurable data/address width, external synchronous memory port and a NUM_INT-channel vectored, prioritised interrupt controller with HALT-until-interrupt. It sits between a single-port synchronous RAM (program + data + stack) and the board-level interrupt sources.

## Interface
- DATA_W, 8: register/ALU/memory word width (≥8; instruction uses bits [7:0]).
- ADDR_W, 8: memory address width (≤ DATA_W); addresses use register bits [ADDR_W-1:0].
- NUM_INT, 4: interrupt channels (1..8).
- RESET_PC, 8: pc after reset.
- VEC_BASE, 2: vector for channel i is VEC_BASE+i.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NUM_INT  interrupt requests, synchronous to clk, rising-edge triggered.
- mem_addr  out  ADDR_W  memory address (combinational from state).
- mem_wdata  out  DATA_W  write data.
- mem_we  out  1  write strobe, one cycle per write.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_addr presented.
- irq_ack  out  NUM_INT  one-hot, one-cycle pulse when channel i is taken.
- halted  out  1  high while in HALT.

## Operation
- Registers r0..r3 (DATA_W), pc, sp (ADDR_W), ir (8), ie, pending[NUM_INT]. Instruction byte: op=[7:4], rd=[3:2], rs=[1:0]. All arithmetic wraps mod 2^width.
- 0 ADD rd+=rs; 1 SUB rd-=rs; 2 NAND rd=~(rd&rs); 3 XOR rd^=rs; 4 MOV rd=rs; 5 LDI rd=next word; 6 LD rd=mem[rs]; 7 ST mem[rs]=rd; 8 BEQ: if rd==rs pc=next word else skip it; 9 JMP next word; A CALL: push return addr, pc=next word; B RET (ir[0]=1: RETI, also ie=1); C PUSH rd; D POP rd; E ir[0]→ie; F ir[0]=0 NOP, =1 HALT.
- Stack: push writes mem[sp] then sp−1; pop sp+1 then reads mem[sp]. sp resets to all ones.
- States: FETCH, DECODE, OPND, EXEC, WB, INT, HALT.
- FETCH: if ie && |pending → INT; else mem_addr=pc → DECODE.
- DECODE: ir=mem_rdata, pc+1; ops 5,8,9,A → OPND (mem_addr=pc, pc+1); else → EXEC.
- EXEC: ALU/MOV/E/NOP write back → FETCH; ST, PUSH, CALL issue write → FETCH; LD/POP/RET issue read → WB; HALT → HALT.
- WB: write mem_rdata to rd or pc → FETCH.
- INT: lowest-index pending channel i: mem[sp]=pc, sp−1, pc=VEC_BASE+i, pending[i]=0, ie=0, irq_ack[i]=1 → FETCH. No nesting.
- HALT: leave when |pending; → FETCH (taken there if ie=1, else resume next instruction; pending retained).
- Edge detect irq & ~irq_q; irq_q resets 0 (input high at reset release counts as edge). New edge and clear on same channel same cycle: pending stays 1.

## Timing
- Reset: state FETCH, pc=RESET_PC, sp=all ones, r0..r3=0, ir=0, ie=0, pending=0; outputs mem_addr=RESET_PC, mem_we=0, mem_wdata=0, irq_ack=0, halted=0.
- Cycles: ALU/MOV/E/NOP/ST/PUSH 3; LD/POP/RET/LDI/JMP/BEQ/CALL 4; interrupt entry 1 + normal fetch.
- Interrupt latency: edge at cycle n → pending at n+1 → taken at next FETCH.
- Reset mid-instruction aborts immediately; no partial write completes after rst rises.

## Structure
- up_core_p_pkg: opcode constants, state enum, sub-op bit positions.
- Sub-module up_irq_ctrl: edge detect, pending, priority encoder, irq_ack generation.

## Test plan
- Reset release, program LDI r0,5; LDI r1,3; SUB r0,r1 → r0=2 at cycle 11; ADD wrap 0xFF+0x01 → 0x00.
- PUSH r2 (=0xA5) then POP r3 → mem[0xFF]=0xA5, r3=0xA5, sp back to 0xFF.
- CALL 0x40 from 0x10, RET at 0x40 → mem[0xFF]=0x12, pc returns to 0x12.
- EI; irq[2] and irq[1] pulse same cycle → irq_ack[1] first, pc=0x03; RETI then channel 2 taken, pc=0x04.
- HALT with ie=0, irq[0] pulse → halted falls, resumes next instruction, pending[0] still 1, taken after EI.
- rst asserted during CALL EXEC → mem_we low same cycle, all registers at reset values.
